// File: rtl/seg7_pkg.sv
// Shared constants for the 2-digit seven-segment scan driver.
// Segment patterns are active-low {g,f,e,d,c,b,a}; anode enables are active-low.
package seg7_pkg;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    localparam logic [1:0] AN_OFF   = 2'b11;
    localparam logic [1:0] AN_TENS  = 2'b01;
    localparam logic [1:0] AN_UNITS = 2'b10;

    // Which digit the current scan slot drives.
    typedef enum logic {
        SLOT_UNITS = 1'b0,
        SLOT_TENS  = 1'b1
    } slot_e;

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Bundle between the numeric datapath / board pins and the scan driver.
interface seg7_scan_driver_if;

    logic [3:0] bcd_tens;
    logic [3:0] bcd_units;
    logic       blank_lz;
    logic       blink_en;
    logic [6:0] seg;
    logic [1:0] an;
    logic       frame_start;

    modport master (
        output bcd_tens, bcd_units, blank_lz, blink_en,
        input  seg, an, frame_start
    );

    modport slave (
        input  bcd_tens, bcd_units, blank_lz, blink_en,
        output seg, an, frame_start
    );

endinterface

// File: rtl/seg7_decode.sv
// BCD to active-low seven-segment pattern; non-BCD codes show a dash.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    // Pure lookup, codes 10..15 fall through to the dash.
    always_comb begin
        o_seg = SEG_DASH;
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Two-digit common-anode scan driver: refresh prescaler, frame-synchronous
// input snapshot, leading-zero blanking, blinking, registered seg/an outputs.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    seg7_scan_driver_if.slave   bus
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    logic [PW-1:0] r_presc;
    slot_e         r_idx;
    logic [3:0]    r_sh_tens;
    logic [3:0]    r_sh_units;
    logic [BW-1:0] r_blink_cnt;
    logic          r_blink_ph;
    logic [6:0]    r_seg;
    logic [1:0]    r_an;
    logic          r_frame_start;

    logic          w_tick;
    logic          w_snap;
    logic [3:0]    w_digit;
    logic [6:0]    w_dec;
    logic          w_blank;

    assign w_tick  = (r_presc == PRESC_LAST);
    // A frame ends after the tens slot; that is the only point inputs are sampled.
    assign w_snap  = w_tick && (r_idx == SLOT_TENS);
    assign w_digit = (r_idx == SLOT_TENS) ? r_sh_tens : r_sh_units;
    // blank_lz acts on the live input but on the snapshotted tens value.
    assign w_blank = (bus.blink_en && r_blink_ph) ||
                     ((r_idx == SLOT_TENS) && bus.blank_lz && (r_sh_tens == 4'd0));

    seg7_decode u_decode (
        .i_bcd (w_digit),
        .o_seg (w_dec)
    );

    // Refresh prescaler, wraps at REFRESH_DIV-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_presc <= '0;
        else if (w_tick) r_presc <= '0;
        else             r_presc <= r_presc + 1'b1;
    end

    // Slot index toggles every tick: units slot first, then tens slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_idx <= SLOT_UNITS;
        else if (w_tick) r_idx <= (r_idx == SLOT_TENS) ? SLOT_UNITS : SLOT_TENS;
    end

    // Shadow copy of the digits plus the one-cycle frame_start marker.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh_tens     <= 4'd0;
            r_sh_units    <= 4'd0;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_snap;
            if (w_snap) begin
                r_sh_tens  <= bus.bcd_tens;
                r_sh_units <= bus.bcd_units;
            end
        end
    end

    // Blink timebase counts frames whether or not blinking is enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blink_cnt <= '0;
            r_blink_ph  <= 1'b0;
        end else if (w_snap) begin
            if (r_blink_cnt == BLINK_LAST) begin
                r_blink_cnt <= '0;
                r_blink_ph  <= ~r_blink_ph;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end

    // seg and an share one register stage so they always change together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg <= SEG_BLANK;
            r_an  <= AN_OFF;
        end else if (w_blank) begin
            r_seg <= SEG_BLANK;
            r_an  <= AN_OFF;
        end else begin
            r_seg <= w_dec;
            r_an  <= (r_idx == SLOT_TENS) ? AN_TENS : AN_UNITS;
        end
    end

    assign bus.seg         = r_seg;
    assign bus.an          = r_an;
    assign bus.frame_start = r_frame_start;

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Consumes the two BCD digits produced by the binary-to-BCD stage: tens and units.
- Drives a 2-digit, common-anode, time-multiplexed seven-segment display.
- Provides a refresh prescaler, frame-synchronous input snapshot (no tearing), leading-zero blanking, blinking and an invalid-code indication.
- Sits between the numeric datapath and the board display pins.

Parameters:
- REFRESH_DIV, 50000, clock cycles per digit slot; legal range ≥ 2.
- BLINK_FRAMES, 64, number of scan frames per blink half-period; legal range ≥ 1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous reset, active-low
- bcd_tens  in  4  tens digit, BCD
- bcd_units  in  4  units digit, BCD
- blank_lz  in  1  1 = blank the tens digit when it is 0
- blink_en  in  1  1 = blink the whole display
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- an  out  2  anode enables, an[1]=tens, an[0]=units, active-low
- frame_start  out  1  one-cycle pulse when a new input snapshot is taken

Behaviour:
- Reset (rst_n=0, asynchronous; cleared synchronously in effect after release):
  - Outputs: seg=7'h7F, an=2'b11, frame_start=0.
  - Internal state: prescaler=0, digit index idx=0 (units), shadow tens/units=0, blink counter=0, blink phase=0.
- Reset mid-scan: aborts immediately; scanning restarts from idx=0 with a full slot.
- Prescaler:
  - Counts 0..REFRESH_DIV-1 and wraps.
  - tick = (prescaler == REFRESH_DIV-1).
- Digit index:
  - Toggles on every tick.
  - One frame = 2 slots: units slot (idx=0), then tens slot (idx=1).
- Snapshot:
  - On a tick with idx=1, shadow_tens/shadow_units capture bcd_tens/bcd_units.
  - frame_start is registered high for exactly the next cycle.
  - Input changes between snapshots never reach the outputs.
- Blink:
  - The blink counter increments on each snapshot.
  - When it reaches BLINK_FRAMES-1 it wraps to 0 and blink phase toggles.
  - The counter runs regardless of blink_en.
- Output stage, registered each cycle from the current idx and shadow values:
  - Latency is exactly one clock after an idx or shadow change.
  - Digit selected: d = idx ? shadow_tens : shadow_units.
  - an = idx ? 2'b01 : 2'b10.
  - an forced to 2'b11 if blink_en=1 and blink phase=1.
  - an forced to 2'b11 if idx=1, blank_lz=1 and shadow_tens==0. blank_lz is sampled live, not snapshotted.
  - seg = decode(d) when the digit is enabled, else 7'h7F.
- Decode, active-low {g..a}:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
  - Codes 10–15 show a dash: 3F (g only).
- seg and an always update on the same edge, so no ghost digit appears for more than 0 cycles.
- No handshake with the upstream stage. It must hold valid BCD at least across the snapshot edge; frame_start is available for alignment.

Decomposition:
- Shared package or include (seg7_pkg):
  - The ten digit pattern constants.
  - SEG_BLANK=7'h7F.
  - SEG_DASH=7'h3F.
  - AN_OFF=2'b11.
- One natural sub-module: seg7_decode, combinational, 4-bit BCD in, 7-bit active-low pattern out.
- The top holds the prescaler, idx, shadow, blink logic and output registers.

Test Plan (REFRESH_DIV=4, BLINK_FRAMES=2):
- Reset release with tens=4, units=2:
  - seg=7F, an=11 during reset.
  - After the first snapshot (cycle 8): tens slot shows an=01, seg=19; units slot shows an=10, seg=24.
  - frame_start pulses once every 8 cycles.
- Change units 2→7 mid-frame (cycle 10):
  - Outputs keep pattern 24 until the next snapshot at cycle 16.
  - After that, the units slot shows 78.
- blank_lz=1, tens=0, units=5: tens slot an=11, seg=7F; units slot an=10, seg=12.
- blank_lz=0, same inputs: tens slot an=01, seg=40.
- tens=12, units=15: both slots show seg=3F.
- blink_en=1: an=11 for 2 frames (16 cycles), active for 2 frames, repeating.
- Assert rst_n=0 mid tens slot: seg=7F and an=11 immediately, with no clock edge needed; scanning resumes at idx=0 after release.
